// File: rtl/ddc_cfg_axil_if.sv
// AXI4-Lite bus bundle for the DDC configuration block (5-bit address, 32-bit data).
interface ddc_cfg_axil_if;
  logic [4:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/ddc_cfg_axil.sv
// AXI4-Lite configuration slave for a multi-channel DDC: phase table commits, downsample
// rate, enable and resync control.
module ddc_cfg_axil #(
  parameter int unsigned  N_CH   = 4,
  parameter int unsigned  DS_MAX = 1024,
  localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  ddc_cfg_axil_if.slave    axi,
  output logic             phase_wr_en,
  output logic [CH_W-1:0]  phase_wr_ch,
  output logic [63:0]      phase_wr_data,
  output logic [31:0]      ds_rate,
  output logic             ddc_enable,
  output logic             resync
);
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StHaveAw, StHaveW, StResp} wr_state_e;

  wr_state_e         wr_state_q;
  logic [2:0]        aw_idx_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [CH_W-1:0]   channel_q, channel_d;
  logic [31:0]       pinc_q, pinc_d, poff_q, poff_d, ds_rate_q, ds_rate_d;
  logic              ddc_enable_q, ddc_enable_d, resync_q, resync_d;
  logic [15:0]       status_q;
  logic              phase_wr_en_q;
  logic [CH_W-1:0]   phase_wr_ch_q;
  logic [63:0]       phase_wr_data_q;
  logic              bvalid_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q, wr_resp, rd_resp;
  logic [31:0]       rdata_q, rd_data, wr_data, ds_merge;
  logic [3:0]        wr_strb;
  logic [2:0]        wr_idx;
  logic              wr_go, commit;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  // Pick address/data from the live channel or from whichever half was captured first.
  always_comb begin
    wr_idx  = (wr_state_q == StHaveAw) ? aw_idx_q : axi.s_axi_awaddr[4:2];
    wr_data = (wr_state_q == StHaveW) ? w_data_q : axi.s_axi_wdata;
    wr_strb = (wr_state_q == StHaveW) ? w_strb_q : axi.s_axi_wstrb;
    unique case (wr_state_q)
      StIdle:   wr_go = axi.s_axi_awvalid & axi.s_axi_wvalid;
      StHaveAw: wr_go = axi.s_axi_wvalid;
      StHaveW:  wr_go = axi.s_axi_awvalid;
      default:  wr_go = 1'b0;
    endcase
  end

  always_comb begin
    channel_d    = channel_q;
    pinc_d       = pinc_q;
    poff_d       = poff_q;
    ds_rate_d    = ds_rate_q;
    ddc_enable_d = ddc_enable_q;
    resync_d     = 1'b0;
    commit       = 1'b0;
    wr_resp      = RespOkay;
    ds_merge     = merge_strb(ds_rate_q, wr_data, wr_strb);
    unique case (wr_idx)
      3'd0: if (wr_strb[0]) begin
        if (wr_data < 32'(N_CH)) begin
          channel_d = wr_data[CH_W-1:0];
          commit    = 1'b1;
        end else begin
          wr_resp = RespSlvErr;
        end
      end
      3'd1: pinc_d = merge_strb(pinc_q, wr_data, wr_strb);
      3'd2: poff_d = merge_strb(poff_q, wr_data, wr_strb);
      3'd3: begin
        if (ds_merge == 32'd0 || ds_merge > 32'(DS_MAX)) wr_resp = RespSlvErr;
        else ds_rate_d = ds_merge;
      end
      3'd4: if (wr_strb[0]) begin
        ddc_enable_d = wr_data[0];
        resync_d     = wr_data[1];
      end
      default: wr_resp = RespSlvErr;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    unique case (axi.s_axi_araddr[4:2])
      3'd0:    rd_data = 32'(channel_q);
      3'd1:    rd_data = pinc_q;
      3'd2:    rd_data = poff_q;
      3'd3:    rd_data = ds_rate_q;
      3'd4:    rd_data = {31'b0, ddc_enable_q};
      3'd5:    rd_data = {16'b0, status_q};
      default: rd_resp = RespSlvErr;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      wr_state_q      <= StIdle;
      aw_idx_q        <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      channel_q       <= '0;
      pinc_q          <= '0;
      poff_q          <= '0;
      ds_rate_q       <= 32'd1;
      ddc_enable_q    <= 1'b0;
      resync_q        <= 1'b0;
      status_q        <= '0;
      phase_wr_en_q   <= 1'b0;
      phase_wr_ch_q   <= '0;
      phase_wr_data_q <= '0;
      bvalid_q        <= 1'b0;
      bresp_q         <= RespOkay;
      rvalid_q        <= 1'b0;
      rresp_q         <= RespOkay;
      rdata_q         <= '0;
    end else begin
      phase_wr_en_q <= 1'b0;
      resync_q      <= 1'b0;
      if (wr_go) begin
        channel_q    <= channel_d;
        pinc_q       <= pinc_d;
        poff_q       <= poff_d;
        ds_rate_q    <= ds_rate_d;
        ddc_enable_q <= ddc_enable_d;
        resync_q     <= resync_d;
        bvalid_q     <= 1'b1;
        bresp_q      <= wr_resp;
        wr_state_q   <= StResp;
        if (commit) begin
          phase_wr_en_q   <= 1'b1;
          phase_wr_ch_q   <= channel_d;
          phase_wr_data_q <= {poff_q, pinc_q};
          status_q        <= status_q + 16'd1;
        end
      end else begin
        unique case (wr_state_q)
          StIdle: begin
            if (axi.s_axi_awvalid) begin
              aw_idx_q   <= axi.s_axi_awaddr[4:2];
              wr_state_q <= StHaveAw;
            end else if (axi.s_axi_wvalid) begin
              w_data_q   <= axi.s_axi_wdata;
              w_strb_q   <= axi.s_axi_wstrb;
              wr_state_q <= StHaveW;
            end
          end
          StResp: if (axi.s_axi_bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= StIdle;
          end
          default: ;
        endcase
      end
      // Reads sample registers before this cycle's write lands.
      if (rvalid_q) begin
        if (axi.s_axi_rready) rvalid_q <= 1'b0;
      end else if (axi.s_axi_arvalid) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end
    end
  end

  assign axi.s_axi_awready = ~axi_rst & ((wr_state_q == StIdle) | (wr_state_q == StHaveW));
  assign axi.s_axi_wready  = ~axi_rst & ((wr_state_q == StIdle) | (wr_state_q == StHaveAw));
  assign axi.s_axi_bvalid  = bvalid_q;
  assign axi.s_axi_bresp   = bresp_q;
  assign axi.s_axi_arready = ~axi_rst & ~rvalid_q;
  assign axi.s_axi_rvalid  = rvalid_q;
  assign axi.s_axi_rresp   = rresp_q;
  assign axi.s_axi_rdata   = rdata_q;

  assign phase_wr_en   = phase_wr_en_q;
  assign phase_wr_ch   = phase_wr_ch_q;
  assign phase_wr_data = phase_wr_data_q;
  assign ds_rate       = ds_rate_q;
  assign ddc_enable    = ddc_enable_q;
  assign resync        = resync_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};
endmodule

// File: tb/tb_ddc_cfg_axil.sv
// Directed self-checking bench for ddc_cfg_axil with hand-computed expectations.
module tb_ddc_cfg_axil;
  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b1;
  logic        phase_wr_en;
  logic [1:0]  phase_wr_ch;
  logic [63:0] phase_wr_data;
  logic [31:0] ds_rate;
  logic        ddc_enable;
  logic        resync;

  ddc_cfg_axil_if bus ();

  ddc_cfg_axil #(.N_CH(4), .DS_MAX(1024)) dut (
    .axi_clk       (axi_clk),
    .axi_rst       (axi_rst),
    .axi           (bus.slave),
    .phase_wr_en   (phase_wr_en),
    .phase_wr_ch   (phase_wr_ch),
    .phase_wr_data (phase_wr_data),
    .ds_rate       (ds_rate),
    .ddc_enable    (ddc_enable),
    .resync        (resync)
  );

  always #5 axi_clk = ~axi_clk;

  int errors = 0;
  int checks = 0;

  // Commit/resync monitor sampled on the falling edge.
  int          pwe_cnt = 0;
  int          pwe_nobv = 0;
  int          rs_cnt = 0;
  logic [1:0]  pwe_ch [16];
  logic [63:0] pwe_data [16];

  always @(negedge axi_clk) begin
    if (!axi_rst) begin
      if (phase_wr_en) begin
        if (pwe_cnt < 16) begin
          pwe_ch[pwe_cnt]   = phase_wr_ch;
          pwe_data[pwe_cnt] = phase_wr_data;
        end
        if (!bus.s_axi_bvalid) pwe_nobv++;
        pwe_cnt++;
      end
      if (resync) rs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0;
    w_done  = 0;
    n       = 0;
    resp    = 2'b11;
    bus.s_axi_awaddr  = a;
    bus.s_axi_wdata   = d;
    bus.s_axi_wstrb   = s;
    bus.s_axi_awvalid = 1'b1;
    bus.s_axi_wvalid  = 1'b1;
    bus.s_axi_bready  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
      w_hs  = bus.s_axi_wvalid && bus.s_axi_wready;
      tick();
      if (aw_hs) begin bus.s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs) begin bus.s_axi_wvalid = 1'b0; w_done = 1; end
      n++;
    end
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wvalid  = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bus.s_axi_bvalid && n < 20) begin tick(); n++; end
    check("wr_bvalid", bus.s_axi_bvalid, 1'b1);
    resp = bus.s_axi_bresp;
    tick();
    bus.s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    bus.s_axi_araddr  = a;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_rready  = 1'b1;
    while (!bus.s_axi_arready && n < 20) begin tick(); n++; end
    tick();
    bus.s_axi_arvalid = 1'b0;
    n = 0;
    while (!bus.s_axi_rvalid && n < 20) begin tick(); n++; end
    check("rd_rvalid", bus.s_axi_rvalid, 1'b1);
    d    = bus.s_axi_rdata;
    resp = bus.s_axi_rresp;
    tick();
    bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          base, rs0, n;

    bus.s_axi_awaddr  = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata   = '0;
    bus.s_axi_wstrb   = '0;
    bus.s_axi_wvalid  = 1'b0;
    bus.s_axi_bready  = 1'b0;
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;

    repeat (3) tick();
    check("rst_awready", bus.s_axi_awready, 1'b0);
    check("rst_bvalid", bus.s_axi_bvalid, 1'b0);
    check("rst_rvalid", bus.s_axi_rvalid, 1'b0);
    check("rst_ds_rate", ds_rate, 32'd1);
    check("rst_enable", ddc_enable, 1'b0);
    check("rst_pwe", phase_wr_en, 1'b0);
    axi_rst = 1'b0;
    tick();
    check("idle_awready", bus.s_axi_awready, 1'b1);

    axi_read(5'h00, rd, resp); check("rst_channel", rd, 32'h0);
    axi_read(5'h04, rd, resp); check("rst_pinc", rd, 32'h0);
    axi_read(5'h0C, rd, resp); check("rst_dsrate_rd", rd, 32'h1);
    axi_read(5'h14, rd, resp); check("rst_status", rd, 32'h0);

    // Four phase-table commits.
    axi_write(5'h04, 32'h0100_0000, 4'hF, resp); check("pinc_resp", resp, 2'b00);
    axi_write(5'h08, 32'h4000_0000, 4'hF, resp); check("poff_resp", resp, 2'b00);
    base = pwe_cnt;
    for (int c = 0; c < 4; c++) begin
      axi_write(5'h00, 32'(c), 4'hF, resp);
      check("chan_resp", resp, 2'b00);
    end
    check("pwe_count", 64'(pwe_cnt - base), 64'd4);
    for (int c = 0; c < 4; c++) begin
      check("pwe_ch", pwe_ch[base + c], 64'(c));
      check("pwe_data", pwe_data[base + c], 64'h4000_0000_0100_0000);
    end
    check("pwe_with_bvalid", 64'(pwe_nobv), 64'd0);
    axi_read(5'h14, rd, resp); check("status_4", rd, 32'd4);

    // Illegal channel and zero rate.
    base = pwe_cnt;
    axi_write(5'h00, 32'd4, 4'hF, resp); check("chan4_slverr", resp, 2'b10);
    axi_write(5'h0C, 32'd0, 4'hF, resp); check("ds0_slverr", resp, 2'b10);
    check("no_pwe_err", 64'(pwe_cnt - base), 64'd0);
    check("ds_stays_1", ds_rate, 32'd1);
    axi_read(5'h00, rd, resp); check("chan_kept_3", rd, 32'd3);

    // Rate and control.
    axi_write(5'h0C, 32'd32, 4'hF, resp); check("ds32_resp", resp, 2'b00);
    check("ds_32", ds_rate, 32'd32);
    rs0 = rs_cnt;
    axi_write(5'h10, 32'h3, 4'hF, resp); check("ctrl_resp", resp, 2'b00);
    check("resync_once", 64'(rs_cnt - rs0), 64'd1);
    check("enable_1", ddc_enable, 1'b1);
    axi_read(5'h10, rd, resp); check("ctrl_rd", rd, 32'h1);
    axi_write(5'h0C, 32'd1025, 4'hF, resp); check("ds1025_slverr", resp, 2'b10);
    check("ds_still_32", ds_rate, 32'd32);
    axi_write(5'h0C, 32'd1024, 4'hF, resp); check("ds1024_resp", resp, 2'b00);
    check("ds_1024", ds_rate, 32'd1024);

    // Byte-lane strobe.
    axi_write(5'h04, 32'h1122_3344, 4'hF, resp);
    axi_write(5'h04, 32'hAABB_CCDD, 4'b0010, resp);
    axi_read(5'h04, rd, resp); check("pinc_strb", rd, 32'h1122_CC44);

    // Unmapped and read-only targets.
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, resp); check("unmap_wr_resp", resp, 2'b10);
    axi_write(5'h14, 32'h0000_0000, 4'hF, resp); check("status_wr_resp", resp, 2'b10);
    axi_read(5'h1C, rd, resp); check("unmap_rd_data", rd, 32'h0);
    check("unmap_rd_resp", resp, 2'b10);
    axi_read(5'h14, rd, resp); check("status_kept", rd, 32'd4);

    // W three cycles ahead of AW, bready stalled five cycles.
    base = pwe_cnt;
    bus.s_axi_wdata  = 32'd7;
    bus.s_axi_wstrb  = 4'hF;
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_bready = 1'b0;
    tick();
    bus.s_axi_wvalid = 1'b0;
    check("havew_wready", bus.s_axi_wready, 1'b0);
    check("havew_awready", bus.s_axi_awready, 1'b1);
    repeat (2) tick();
    check("ds_before_aw", ds_rate, 32'd1024);
    bus.s_axi_awaddr  = 5'h0C;
    bus.s_axi_awvalid = 1'b1;
    tick();
    bus.s_axi_awvalid = 1'b0;
    check("ds_7", ds_rate, 32'd7);
    n = 0;
    repeat (5) begin if (bus.s_axi_bvalid) n++; tick(); end
    check("bvalid_held5", 64'(n), 64'd5);
    check("resp_okay_stall", bus.s_axi_bresp, 2'b00);
    bus.s_axi_bready = 1'b1;
    tick();
    bus.s_axi_bready = 1'b0;
    n = 0;
    repeat (4) begin if (bus.s_axi_bvalid) n++; tick(); end
    check("no_extra_bvalid", 64'(n), 64'd0);
    check("no_pwe_ds", 64'(pwe_cnt - base), 64'd0);

    // Reset between AW and W.
    bus.s_axi_awaddr  = 5'h04;
    bus.s_axi_awvalid = 1'b1;
    tick();
    bus.s_axi_awvalid = 1'b0;
    check("haveaw_awready", bus.s_axi_awready, 1'b0);
    axi_rst = 1'b1;
    tick();
    axi_rst = 1'b0;
    n = 0;
    repeat (4) begin if (bus.s_axi_bvalid) n++; tick(); end
    check("abandon_bvalid", 64'(n), 64'd0);
    check("abandon_ds", ds_rate, 32'd1);
    check("abandon_en", ddc_enable, 1'b0);
    axi_read(5'h04, rd, resp); check("abandon_pinc", rd, 32'h0);
    axi_read(5'h14, rd, resp); check("abandon_status", rd, 32'h0);
    axi_write(5'h04, 32'h0000_0055, 4'hF, resp); check("post_rst_resp", resp, 2'b00);
    axi_read(5'h04, rd, resp); check("post_rst_pinc", rd, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddc_cfg_axil.md
DDC_CFG_AXIL -- requirements
Module: ddc_cfg_axil

Interface
REQ-001 The block SHALL have one clock, axi_clk; reset axi_rst is synchronous and active-high.
REQ-002 Parameter N_CH, default 4: number of DDC channels in the phase table.
REQ-003 Parameter DS_MAX, default 1024: largest legal downsample rate.
REQ-004 Derived CH_W = max(1, clog2(N_CH)).
REQ-005 axi_clk  in  1  clock for all logic.
REQ-006 axi_rst  in  1  synchronous active-high reset.
REQ-007 s_axi_awaddr  in  5; s_axi_awvalid in 1; s_axi_awready out 1: write address channel.
REQ-008 s_axi_wdata  in  32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1: write data channel.
REQ-009 s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1: write response channel.
REQ-010 s_axi_araddr  in  5; s_axi_arvalid in 1; s_axi_arready out 1: read address channel.
REQ-011 s_axi_rdata  out  32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1: read data channel.
REQ-012 phase_wr_en  out  1  one-cycle phase-table commit strobe.
REQ-013 phase_wr_ch  out  CH_W  channel index of commit.
REQ-014 phase_wr_data  out  64  {POFF, PINC} committed.
REQ-015 ds_rate  out  32  current downsample rate.
REQ-016 ddc_enable  out  1  DDC run enable.
REQ-017 resync  out  1  one-cycle phase resync pulse.

Function
REQ-018 Register map (byte address, bits [1:0] ignored): 0x00 CHANNEL, 0x04 PINC, 0x08 POFF, 0x0C DS_RATE, 0x10 CTRL (bit0 enable, bit1 resync, write-only self-clearing), 0x14 STATUS (read-only commit count, 16 bits, wraps).
REQ-019 Write FSM SHALL have states IDLE, HAVE_AW, HAVE_W, RESP; AW and W accepted independently in either order or the same cycle; one write outstanding.
REQ-020 awready high only in IDLE/HAVE_W; wready high only in IDLE/HAVE_AW; neither while bvalid high.
REQ-021 Register update occurs in the cycle both AW and W are held; bvalid rises next cycle and holds until bready; FSM then returns to IDLE.
REQ-022 PINC, POFF, DS_RATE SHALL honour wstrb per byte lane.
REQ-023 CHANNEL write with wstrb[0]=1 and wdata < N_CH: stores index, pulses phase_wr_en with phase_wr_ch=wdata[CH_W-1:0], phase_wr_data={POFF,PINC} in the same cycle bvalid rises; STATUS increments; bresp OKAY.
REQ-024 CHANNEL write with wdata >= N_CH: no commit, CHANNEL unchanged, bresp SLVERR (2'b10).
REQ-025 DS_RATE write resulting in 0 or > DS_MAX: register unchanged, bresp SLVERR.
REQ-026 CTRL write with wstrb[0]=1: ddc_enable <= wdata[0]; resync high exactly one cycle (bvalid-rise cycle) if wdata[1]=1.
REQ-027 Writes to STATUS or unmapped addresses (0x18-0x1C): no side effect, bresp SLVERR.
REQ-028 Read: arready high when rvalid low; rvalid rises cycle after AR handshake, holds with stable rdata until rready.
REQ-029 Reads: CHANNEL zero-extended, PINC, POFF, DS_RATE, CTRL returns {30'b0,0,enable}, STATUS zero-extended; unmapped returns 0 with SLVERR.
REQ-030 Simultaneous read and write SHALL proceed independently; a read in the commit cycle returns pre-write value.
REQ-031 ds_rate and ddc_enable are direct register outputs, updated the cycle bvalid rises.

Reset
REQ-032 On axi_rst: FSMs IDLE; all ready/valid, phase_wr_en, resync, ddc_enable = 0; bresp/rresp = 0; rdata = 0; CHANNEL, PINC, POFF, STATUS = 0; ds_rate = 1.
REQ-033 Reset mid-transaction SHALL abandon it without commit or response.

Verification
REQ-034 Write PINC=0x0100_0000, POFF=0x4000_0000, CHANNEL=0..3 -> four phase_wr_en pulses, ch 0..3, data 0x4000_0000_0100_0000; STATUS reads 4.
REQ-035 W presented 3 cycles before AW, bready held low 5 cycles -> single update, bvalid held 5 cycles, no extra response.
REQ-036 CHANNEL=4 (N_CH=4) and DS_RATE=0 -> both SLVERR, no phase_wr_en, ds_rate stays 1.
REQ-037 DS_RATE=32 then CTRL=0x3 -> ds_rate=32, ddc_enable=1, resync exactly one cycle; CTRL read returns 0x1.
REQ-038 PINC write wstrb=4'b0010 data 0xAABBCCDD over 0x11223344 -> PINC reads 0x1122CC44.
REQ-039 axi_rst asserted between AW and W handshakes -> no bvalid, registers at reset values, next full write succeeds.
